// File: rtl/neuron_core_tm.sv
// Event-driven spiking neuron core: axon events queue in a FIFO, each fetches a synapse
// row and integrates a typed weight; frame_end runs one leak/threshold/fire pass.
module neuron_core_tm #(
    parameter int NUM_AXONS   = 256,
    parameter int NUM_NEURONS = 256,
    parameter int POT_W       = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int RESET_MODE  = 0,
    localparam int AW = $clog2(NUM_AXONS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ev_valid,
    output logic                      ev_ready,
    input  logic [AW-1:0]             ev_axon,
    input  logic [1:0]                ev_type,
    input  logic                      frame_start,
    input  logic                      frame_end,
    input  logic [4*POT_W-1:0]        weight_table,
    input  logic signed [POT_W-1:0]   pos_threshold,
    input  logic signed [POT_W-1:0]   neg_threshold,
    input  logic signed [POT_W-1:0]   pos_reset,
    input  logic signed [POT_W-1:0]   neg_reset,
    input  logic signed [POT_W-1:0]   leak_value,
    output logic                      syn_rd_en,
    output logic [AW-1:0]             syn_rd_addr,
    input  logic [NUM_NEURONS-1:0]    syn_rd_data,
    output logic [NUM_NEURONS-1:0]    spike_o,
    output logic                      done_o,
    output logic                      busy_o
);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [FW:0] PTR_ONE = {{FW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, READ, ACC, FIRE, DONE} state_t;
    state_t state, next_state;

    logic [AW+1:0]           fifo_mem [FIFO_DEPTH];
    logic [FW:0]             wr_ptr, rd_ptr;
    logic                    fifo_empty, fifo_full, push, pop;
    logic [AW-1:0]           head_axon;
    logic [1:0]              head_type, type_r;
    logic                    end_pending;
    logic signed [POT_W-1:0] weight;
    logic signed [POT_W-1:0] pot      [NUM_NEURONS];
    logic signed [POT_W-1:0] acc_val  [NUM_NEURONS];
    logic signed [POT_W-1:0] fire_val [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]  fire_bit;

    function automatic logic signed [POT_W:0] ext(input logic signed [POT_W-1:0] v);
        return {v[POT_W-1], v};
    endfunction

    function automatic logic signed [POT_W-1:0] sat(input logic signed [POT_W:0] v);
        if (v[POT_W] != v[POT_W-1])
            return v[POT_W] ? {1'b1, {(POT_W-1){1'b0}}} : {1'b0, {(POT_W-1){1'b1}}};
        return v[POT_W-1:0];
    endfunction

    // Full/empty come from registered pointers, so a same-cycle pop cannot reopen ev_ready.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FW] != rd_ptr[FW]) && (wr_ptr[FW-1:0] == rd_ptr[FW-1:0]);
    assign ev_ready   = !fifo_full && !frame_start;
    assign push       = ev_valid && ev_ready;
    assign pop        = (state == READ) && !frame_start;
    assign {head_type, head_axon} = fifo_mem[rd_ptr[FW-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[FW-1:0]] <= {ev_type, ev_axon};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (frame_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // A frame_end arriving during FIRE belongs to the next frame, so set beats clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                end_pending <= 1'b0;
        else if (frame_start)    end_pending <= 1'b0;
        else if (frame_end)      end_pending <= 1'b1;
        else if (state == FIRE)  end_pending <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               state <= IDLE;
        else if (frame_start)   state <= IDLE;
        else                    state <= next_state;
    end

    // IDLE looks at the incoming push and frame_end directly to save a cycle of latency.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!fifo_empty || push)        next_state = READ;
                else if (end_pending || frame_end) next_state = FIRE;
            end
            READ:    next_state = ACC;
            ACC:     next_state = IDLE;
            FIRE:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                type_r <= 2'd0;
        else if (state == READ)  type_r <= head_type;
    end

    assign weight = weight_table[type_r*POT_W +: POT_W];

    always_comb begin
        logic signed [POT_W-1:0] p;
        p        = '0;
        fire_bit = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            acc_val[n]  = sat(ext(pot[n]) + ext(weight));
            p           = sat(ext(pot[n]) - ext(leak_value));
            fire_val[n] = p;
            if (p >= pos_threshold) begin
                fire_bit[n] = 1'b1;
                if (RESET_MODE != 0) fire_val[n] = sat(ext(p) - ext(pos_threshold));
                else                 fire_val[n] = pos_reset;
            end else if (p < neg_threshold) begin
                fire_val[n] = neg_reset;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spike_o <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) pot[n] <= '0;
        end else if (frame_start) begin
            spike_o <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) pot[n] <= '0;
        end else if (state == ACC) begin
            for (int n = 0; n < NUM_NEURONS; n++)
                if (syn_rd_data[n]) pot[n] <= acc_val[n];
        end else if (state == FIRE) begin
            spike_o <= fire_bit;
            for (int n = 0; n < NUM_NEURONS; n++) pot[n] <= fire_val[n];
        end
    end

    assign syn_rd_en   = pop;
    assign syn_rd_addr = (state == READ) ? head_axon : '0;
    assign done_o      = (state == DONE);
    assign busy_o      = (state != IDLE) || !fifo_empty || end_pending;

endmodule
